// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
package imem_pkg;

   localparam int unsigned IMEM_DEPTH = 256;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_FILL  = 3'd3,
      ST_DONE  = 3'd4
   } loader_state_e;

endpackage

// File: rtl/imem_csum.sv
// Wrapping 32-bit accumulator with synchronous clear and add enable.
module imem_csum (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        add,
   input  logic [31:0] data,
   output logic [31:0] sum
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
      end else if (clr) begin
         sum <= '0;
      end else if (add) begin
         sum <= sum + data;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a program image into instruction memory, pads with NOPs,
// then releases the core. IMEM_LOADER_CHECKSUM_EN adds a running word checksum.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH    = IMEM_DEPTH,
   parameter logic [31:0] NOP_WORD = imem_pkg::NOP_WORD
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [31:0]                s_data,
   input  logic                       s_last,
   output logic                       mem_we,
   output logic [$clog2(DEPTH)-1:0]   mem_waddr,
   output logic [31:0]                mem_wdata,
   output logic                       core_rst_n,
   output logic                       busy,
   output logic                       done,
   output logic                       err,
   output logic [$clog2(DEPTH):0]     words_loaded,
   output logic [31:0]                checksum
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   loader_state_e state;
   loader_state_e state_next;
   logic [AW-1:0] ptr;
   logic          load_start;
   logic          stream_we;
   logic          at_last;

   assign at_last    = (ptr == LAST_IDX);
   assign load_start = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign stream_we  = (state == ST_LOAD) && s_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_LOAD;
         ST_LOAD: begin
            if (s_valid) begin
               if (s_last)       state_next = at_last ? ST_DONE : ST_FILL;
               else if (at_last) state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: if (s_valid && s_last) state_next = ST_DONE;
         ST_FILL:  if (at_last) state_next = ST_DONE;
         ST_DONE:  if (start) state_next = ST_LOAD;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Status decodes come from registered state only; the write port follows the accepted beat.
   always_comb begin
      s_ready    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      core_rst_n = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = ptr;
      mem_wdata  = '0;
      case (state)
         ST_LOAD: begin
            s_ready   = 1'b1;
            busy      = 1'b1;
            mem_we    = s_valid;
            mem_wdata = s_data;
         end
         ST_DRAIN: begin
            s_ready = 1'b1;
            busy    = 1'b1;
         end
         ST_FILL: begin
            busy      = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = NOP_WORD;
         end
         ST_DONE: begin
            done       = 1'b1;
            core_rst_n = 1'b1;
         end
         default: ;
      endcase
   end

   // Pointer holds at the top index rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr          <= '0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else if (load_start) begin
         ptr          <= '0;
         err          <= 1'b0;
         words_loaded <= '0;
      end else begin
         if (mem_we && !at_last) begin
            ptr <= ptr + AW'(1);
         end
         if (stream_we && (words_loaded != CW'(DEPTH))) begin
            words_loaded <= words_loaded + CW'(1);
         end
         if (stream_we && !s_last && at_last) begin
            err <= 1'b1;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   imem_csum u_csum (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (load_start),
      .add   (stream_we),
      .data  (s_data),
      .sum   (checksum)
   );
`else
   assign checksum = '0;
`endif

endmodule
